// File: rtl/flopr_sync_n.sv
// flopr_sync_n: WIDTH-bit rising-edge D register with synchronous active-low reset.
// Generic storage primitive for peripheral state such as an interrupt pending vector.
// It has no enable. It captures d on every PCLK edge unless PRESETn is sampled low.
module flopr_sync_n #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // State register: reset has priority over d and acts only at the clock edge.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= d;
    end
  end

  // Drive q straight from the flop so there is no combinational path to the output.
  assign q = q_q;

endmodule

// File: tb/tb_flopr_sync_n.sv
// tb_flopr_sync_n: randomized and directed checks of flopr_sync_n against a behavioural model.
// Four instances cover the default reset value, a non-zero reset value, a wide width and WIDTH=1.
module tb_flopr_sync_n;

  localparam logic [7:0] RV_B = 8'h3C;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [7:0]  d8;
  logic [7:0]  q8a;
  logic [7:0]  q8b;
  logic [62:0] d63;
  logic [62:0] q63;
  logic        d1;
  logic        q1;

  // Expected outputs of the behavioural model.
  logic [7:0]  e8a;
  logic [7:0]  e8b;
  logic [62:0] e63;
  logic        e1;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  flopr_sync_n #(.WIDTH(8)) u_dut_8a (
    .PCLK(PCLK), .PRESETn(PRESETn), .d(d8), .q(q8a)
  );

  flopr_sync_n #(.WIDTH(8), .RESET_VAL(RV_B)) u_dut_8b (
    .PCLK(PCLK), .PRESETn(PRESETn), .d(d8), .q(q8b)
  );

  flopr_sync_n #(.WIDTH(63)) u_dut_63 (
    .PCLK(PCLK), .PRESETn(PRESETn), .d(d63), .q(q63)
  );

  flopr_sync_n #(.WIDTH(1)) u_dut_1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .d(d1), .q(q1)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: the value seen after an edge is d if reset was high at that edge, else RESET_VAL.
  task automatic tick();
    e8a = PRESETn ? d8  : 8'h00;
    e8b = PRESETn ? d8  : RV_B;
    e63 = PRESETn ? d63 : 63'd0;
    e1  = PRESETn ? d1  : 1'b0;
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_q8a"}, 64'(q8a), 64'(e8a));
    check_eq({tag, "_q8b"}, 64'(q8b), 64'(e8b));
    check_eq({tag, "_q63"}, 64'(q63), 64'(e63));
    check_eq({tag, "_q1"},  64'(q1),  64'(e1));
  endtask

  initial begin
    logic [7:0] vals [3];
    vals[0] = 8'h5A;
    vals[1] = 8'hFF;
    vals[2] = 8'h00;

    // Reset held across two edges with d active.
    PRESETn = 1'b0;
    d8      = 8'hA5;
    d63     = 63'h7FFF_FFFF_FFFF_FFFF;
    d1      = 1'b1;
    tick();
    check_eq("rst1_default", 64'(q8a), 64'h00);
    check_eq("rst1_rv3c",    64'(q8b), 64'h3C);
    check_all("rst1");
    tick();
    check_all("rst2");

    // Capture with one-edge latency, and q holds between edges when d changes.
    PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d8 = vals[i];
      tick();
      check_eq("capture", 64'(q8a), 64'(vals[i]));
      d8 = ~vals[i];
      #3;
      check_eq("hold_between_edges", 64'(q8a), 64'(vals[i]));
      d8 = vals[i];
    end

    // Short reset pulse between edges must not affect q.
    d8 = 8'hFF;
    tick();
    check_eq("pre_pulse", 64'(q8a), 64'hFF);
    PRESETn = 1'b0;
    #3;
    check_eq("pulse_low_a", 64'(q8a), 64'hFF);
    check_eq("pulse_low_b", 64'(q8b), 64'hFF);
    PRESETn = 1'b1;
    #1;
    check_eq("pulse_after", 64'(q8b), 64'hFF);

    // Reset held across an edge with d=FF: reset wins, then capture resumes.
    PRESETn = 1'b0;
    tick();
    check_eq("prio_a", 64'(q8a), 64'h00);
    check_eq("prio_b", 64'(q8b), 64'h3C);
    PRESETn = 1'b1;
    tick();
    check_eq("release_a", 64'(q8a), 64'hFF);
    check_eq("release_b", 64'(q8b), 64'hFF);

    // Wide instance bit-exact.
    d63 = 63'h4000_0000_0000_0001;
    tick();
    check_eq("wide63", 64'(q63), 64'h4000_0000_0000_0001);

    // Single-bit instance toggling.
    for (int i = 0; i < 6; i++) begin
      d1 = ~d1;
      tick();
      check_eq("narrow_toggle", 64'(q1), 64'(d1));
    end

    // Random traffic with about 5% of edges in reset.
    for (int i = 0; i < 10000; i++) begin
      PRESETn = ($urandom_range(0, 99) >= 5);
      d8      = 8'($urandom);
      d63     = 63'({$urandom, $urandom});
      d1      = 1'($urandom);
      tick();
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
